phy_rx_destripe: RTL

- Parametrised receive-side lane merger for the PCI physical-layer RX path; sits after the per-lane serial-to-parallel converters.
- Accepts one byte stream per lane and packs each lane into words. Buffers each lane in a deskew FIFO so inter-lane skew is absorbed.
- Re-interleaves words round-robin (lane 0, 1, ..., LANES-1) into a single word stream, and reports alignment and overflow status.

---
 rtl/phy_rx_pkg.sv | 29 ++
 rtl/phy_rx_lane_buf.sv | 105 ++++++++++
 rtl/phy_rx_destripe.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/phy_rx_pkg.sv
// -----------------------------------------------------------------------------
// phy_rx_pkg
// Shared definitions for the PCI PHY RX lane merger (phy_rx_destripe):
//   - state_e : merger state machine encoding
//   - BYTE_W  : width of one lane byte
//   - clog2() : pointer width helper, never returns less than 1
// -----------------------------------------------------------------------------
package phy_rx_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    ERROR = 2'd3
  } state_e;

  // Bits needed to index 'value' entries; a single entry still gets one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/phy_rx_lane_buf.sv
// -----------------------------------------------------------------------------
// phy_rx_lane_buf
// One lane of the RX merger: packs qualified bytes MSB-first into words and
// buffers completed words in a small deskew FIFO.
// Ports:
//   clk_4f, reset        byte-rate clock, synchronous active-high reset
//   i_byte               lane byte
//   i_valid, i_active    byte is taken only when both are high
//   i_pop                remove the head word (ignored when empty)
//   i_flush              drop the partial word and empty the FIFO
//   o_head_c             word at the FIFO head
//   o_empty_c, o_full_c  FIFO occupancy flags
//   o_overflow_pulse_c   a completed word was dropped this cycle
// -----------------------------------------------------------------------------
module phy_rx_lane_buf
  import phy_rx_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                             clk_4f,
  input  logic                             reset,
  input  logic [BYTE_W-1:0]                i_byte,
  input  logic                             i_valid,
  input  logic                             i_active,
  input  logic                             i_pop,
  input  logic                             i_flush,
  output logic [BYTES_PER_WORD*BYTE_W-1:0] o_head_c,
  output logic                             o_empty_c,
  output logic                             o_full_c,
  output logic                             o_overflow_pulse_c
);

  localparam int unsigned WORD_W = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned CNT_W  = clog2(BYTES_PER_WORD);
  localparam int unsigned AW     = clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = AW + 1;

  logic [CNT_W-1:0]  r_byte_cnt;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;

  logic              w_take;
  logic              w_word_done;
  logic              w_pop_ok;
  logic              w_push_ok;
  logic [WORD_W-1:0] w_word_asm;

  assign w_take      = i_valid & i_active;
  assign w_word_done = w_take & (r_byte_cnt == CNT_W'(BYTES_PER_WORD - 1));
  // Earlier bytes shift toward the MSB, so the first byte ends up on top.
  assign w_word_asm  = (r_word << BYTE_W) | WORD_W'(i_byte);

  assign o_empty_c = (r_occ == '0);
  assign o_full_c  = (r_occ == OCC_W'(FIFO_DEPTH));
  assign o_head_c  = r_mem[r_rd_ptr];

  // A simultaneous pop frees the slot, so a push into a full FIFO is still legal.
  assign w_pop_ok           = i_pop & ~o_empty_c;
  assign w_push_ok          = w_word_done & (~o_full_c | w_pop_ok);
  assign o_overflow_pulse_c = w_word_done & o_full_c & ~w_pop_ok;

  // Byte packer
  always_ff @(posedge clk_4f) begin
    if (reset || i_flush) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (w_take) begin
      r_word     <= w_word_asm;
      r_byte_cnt <= w_word_done ? '0 : r_byte_cnt + CNT_W'(1);
    end
  end

  // FIFO storage; contents are don't-care once the occupancy is cleared
  always_ff @(posedge clk_4f) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= w_word_asm;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_4f) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/phy_rx_destripe.sv
// -----------------------------------------------------------------------------
// phy_rx_destripe
// RX lane merger: packs each lane into words, absorbs inter-lane skew in
// per-lane FIFOs and re-interleaves words round-robin (lane 0 first).
// Ports:
//   clk_4f          byte-rate clock
//   reset           synchronous active-high reset
//   lane_data_in    one byte per lane, lane k at [8k+7:8k]
//   lane_valid_in   per-lane byte qualifier
//   lane_active_in  per-lane sync flag; any low lane drops back to IDLE
//   data_out        merged word (registered, holds when valid_out is low)
//   valid_out       data_out qualifier
//   aligned         high while merging (RUN)
//   overflow_err    sticky FIFO overflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module phy_rx_destripe
  import phy_rx_pkg::*;
#(
  parameter int unsigned LANES          = 2,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                             clk_4f,
  input  logic                             reset,
  input  logic [BYTE_W*LANES-1:0]          lane_data_in,
  input  logic [LANES-1:0]                 lane_valid_in,
  input  logic [LANES-1:0]                 lane_active_in,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] data_out,
  output logic                             valid_out,
  output logic                             aligned,
  output logic                             overflow_err
);

  localparam int unsigned WORD_W = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned PTR_W  = clog2(LANES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [PTR_W-1:0]  w_ptr_adv;
  logic [WORD_W-1:0] w_data_nxt;
  logic              w_valid_nxt;
  logic              w_aligned_nxt;
  logic              w_ovf_nxt;
  logic              w_flush;

  logic [WORD_W-1:0] w_head [LANES];
  logic [LANES-1:0]  w_empty;
  logic [LANES-1:0]  w_full;
  logic [LANES-1:0]  w_ovf_pulse;
  logic [LANES-1:0]  w_pop;
  logic [WORD_W-1:0] w_head_sel;
  logic              w_sel_empty;
  logic              w_all_active;
  logic              w_all_ready;
  logic              w_any_ovf;

  assign w_all_active = &lane_active_in;
  assign w_all_ready  = ~|w_empty;
  // A dropped word always lands on a full FIFO.
  assign w_any_ovf    = |(w_ovf_pulse & w_full);
  assign w_ptr_adv    = (r_ptr == PTR_W'(LANES - 1)) ? '0 : r_ptr + PTR_W'(1);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    phy_rx_lane_buf #(
      .BYTES_PER_WORD (BYTES_PER_WORD),
      .FIFO_DEPTH     (FIFO_DEPTH)
    ) u_lane_buf (
      .clk_4f             (clk_4f),
      .reset              (reset),
      .i_byte             (lane_data_in[k*BYTE_W +: BYTE_W]),
      .i_valid            (lane_valid_in[k]),
      .i_active           (lane_active_in[k]),
      .i_pop              (w_pop[k]),
      .i_flush            (w_flush),
      .o_head_c           (w_head[k]),
      .o_empty_c          (w_empty[k]),
      .o_full_c           (w_full[k]),
      .o_overflow_pulse_c (w_ovf_pulse[k])
    );
  end

  // Head word and empty flag of the lane the round-robin pointer selects
  always_comb begin
    w_head_sel  = '0;
    w_sel_empty = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      if (r_ptr == PTR_W'(k)) begin
        w_head_sel  = w_head[k];
        w_sel_empty = w_empty[k];
      end
    end
  end

  // Pops depend only on state, so the overflow pulse never feeds back into them
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < LANES; k++) begin
      w_pop[k] = (r_state == RUN) && w_all_active && (r_ptr == PTR_W'(k)) && !w_empty[k];
    end
  end

  // Next-state and registered-output values
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_data_nxt  = data_out;
    w_valid_nxt = 1'b0;
    w_flush     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_all_active) begin
          w_state_nxt = ALIGN;
        end
      end
      ALIGN: begin
        if (!w_all_active) begin
          w_state_nxt = IDLE;
          w_flush     = 1'b1;
        end else if (w_all_ready) begin
          w_state_nxt = RUN;
          w_ptr_nxt   = '0;
        end
      end
      RUN: begin
        if (!w_all_active) begin
          w_state_nxt = IDLE;
          w_flush     = 1'b1;
        end else if (!w_sel_empty) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_head_sel;
          w_ptr_nxt   = w_ptr_adv;
        end
      end
      ERROR: begin
        w_state_nxt = ERROR;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Overflow beats every other transition, including an active drop.
    if (w_any_ovf) begin
      w_state_nxt = ERROR;
      w_valid_nxt = 1'b0;
      w_data_nxt  = data_out;
      w_flush     = 1'b0;
    end

    w_aligned_nxt = (w_state_nxt == RUN);
    w_ovf_nxt     = overflow_err | w_any_ovf;
  end

  // State and output registers
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      aligned      <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      data_out     <= w_data_nxt;
      valid_out    <= w_valid_nxt;
      aligned      <= w_aligned_nxt;
      overflow_err <= w_ovf_nxt;
    end
  end

endmodule
